// File: rtl/ldr_adc_reader_if.sv
// SPI pins between the light-sensor reader (master) and an MCP3008-style ADC (slave).
interface ldr_adc_reader_if;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_mosi;
    logic adc_miso;

    modport master (output adc_cs_n, output adc_sclk, output adc_mosi, input adc_miso);
    modport slave  (input adc_cs_n, input adc_sclk, input adc_mosi, output adc_miso);
endinterface

// File: rtl/ldr_adc_reader.sv
// Periodic single-ended read of a 10-bit light sensor over SPI mode 0, with a
// one-cycle sample strobe and a hysteresis-controlled "dark" LED.
module ldr_adc_reader #(
    parameter int unsigned CLK_DIV       = 25,
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter logic [2:0]  CHANNEL       = 3'd0,
    parameter logic [9:0]  LED_ON_BELOW  = 10'd250,
    parameter logic [9:0]  LED_OFF_ABOVE = 10'd300
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    ldr_adc_reader_if.master        spi,
    output logic [9:0]              sample_value,
    output logic                    sample_valid,
    output logic                    frame_err,
    output logic                    busy,
    output logic                    led
);

    localparam int              TW         = $clog2(SAMPLE_PERIOD + 1);
    localparam int              DW         = $clog2(CLK_DIV + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0]   DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [4:0]      NULL_IDX   = 5'd6;
    localparam logic [4:0]      LAST_IDX   = 5'd16;

    typedef enum logic [2:0] {IDLE, CS_SETUP, SCLK_HIGH, SCLK_LOW, CS_HOLD} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q;
    logic [DW-1:0]   div_q, div_d;
    logic [4:0]      idx_q, idx_d;
    logic [9:0]      shift_q, shift_d;
    logic            null_q, null_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            busy_d;
    logic [9:0]      value_d;
    logic            valid_d, err_d, led_d;
    logic            tick;
    logic            div_last;

    // Command word: start, single-ended, channel D2..D0, then zeros.
    function automatic logic cmd_bit(input logic [4:0] idx);
        case (idx)
            5'd0, 5'd1: cmd_bit = 1'b1;
            5'd2:       cmd_bit = CHANNEL[2];
            5'd3:       cmd_bit = CHANNEL[1];
            5'd4:       cmd_bit = CHANNEL[0];
            default:    cmd_bit = 1'b0;
        endcase
    endfunction

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (!enable) begin
            timer_q <= '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end

    assign tick     = enable && (timer_q == TIMER_LAST);
    assign div_last = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every next value defaults to its held value first, so no path infers a latch.
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        null_d  = null_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy;
        value_d = sample_value;
        valid_d = 1'b0;
        err_d   = 1'b0;
        led_d   = led;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = CS_SETUP;
                    div_d   = '0;
                    idx_d   = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = cmd_bit(5'd0);
                end
            end
            CS_SETUP: begin
                if (div_last) begin
                    state_d = SCLK_HIGH;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SCLK_HIGH: begin
                // The ADC's bit is taken in the first cycle after the rising edge.
                if (div_q == '0) begin
                    if (idx_q == NULL_IDX) begin
                        null_d = spi.adc_miso;
                    end else if (idx_q > NULL_IDX) begin
                        shift_d = {shift_q[8:0], spi.adc_miso};
                    end
                end
                if (div_last) begin
                    state_d = SCLK_LOW;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    mosi_d  = cmd_bit(idx_q + 5'd1);
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SCLK_LOW: begin
                if (div_last) begin
                    div_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = CS_HOLD;
                        cs_n_d  = 1'b1;
                        if (null_q) begin
                            err_d = 1'b1;
                        end else begin
                            value_d = shift_q;
                            valid_d = 1'b1;
                            if (shift_q < LED_ON_BELOW) begin
                                led_d = 1'b1;
                            end else if (shift_q > LED_OFF_ABOVE) begin
                                led_d = 1'b0;
                            end
                        end
                    end else begin
                        state_d = SCLK_HIGH;
                        idx_d   = idx_q + 5'd1;
                        sclk_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            CS_HOLD: begin
                if (div_last) begin
                    state_d = IDLE;
                    div_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            null_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            busy         <= 1'b0;
            sample_value <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            led          <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            null_q       <= null_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            mosi_q       <= mosi_d;
            busy         <= busy_d;
            sample_value <= value_d;
            sample_valid <= valid_d;
            frame_err    <= err_d;
            led          <= led_d;
        end
    end

    assign spi.adc_cs_n = cs_n_q;
    assign spi.adc_sclk = sclk_q;
    assign spi.adc_mosi = mosi_q;

endmodule

// File: tb/tb_ldr_adc_reader.sv
// Bench for ldr_adc_reader: a negedge-sampled ADC model plus a sample/LED reference model.
`timescale 1ns/1ps
module tb_ldr_adc_reader;

    localparam int unsigned CLK_DIV       = 2;
    localparam int unsigned SAMPLE_PERIOD = 200;
    localparam logic [2:0]  CHANNEL       = 3'd5;
    localparam logic [9:0]  LED_ON_BELOW  = 10'd250;
    localparam logic [9:0]  LED_OFF_ABOVE = 10'd300;
    localparam int          CD            = int'(CLK_DIV);
    localparam int          SP            = int'(SAMPLE_PERIOD);
    localparam int          BUDGET        = 2 * SP + 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] sample_value;
    logic       sample_valid;
    logic       frame_err;
    logic       busy;
    logic       led;
    logic       miso_drv = 1'b0;

    ldr_adc_reader_if spi ();
    assign spi.adc_miso = miso_drv;

    ldr_adc_reader #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .CHANNEL       (CHANNEL),
        .LED_ON_BELOW  (LED_ON_BELOW),
        .LED_OFF_ABOVE (LED_OFF_ABOVE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .spi          (spi),
        .sample_value (sample_value),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .busy         (busy),
        .led          (led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int rst_base = 0;

    // Reference model: last good sample and LED state.
    logic [9:0] model_value = 10'd0;
    logic       model_led   = 1'b0;

    task automatic model_sample(input logic [9:0] v, input logic nullb);
        if (!nullb) begin
            model_value = v;
            if (v < LED_ON_BELOW) model_led = 1'b1;
            else if (v > LED_OFF_ABOVE) model_led = 1'b0;
        end
    endtask

    // Observations from the most recent frame.
    int          fr_start, fr_sclk_first, fr_cs_rise, fr_busy_fall;
    int          fr_valid_cnt, fr_err_cnt, fr_both, fr_valid_cyc, fr_rises;
    logic [9:0]  fr_value;
    logic [16:0] fr_mosi;
    logic        fr_busy_at_start, fr_timeout;

    // Waits for chip select, plays the ADC's side of the frame and records what the DUT did.
    task automatic run_frame(input logic [9:0] data, input logic nullb, input int drop_enable_at);
        int          n;
        logic        prev_sclk, prev_cs;
        logic [16:0] mf;
        fr_start = -1; fr_sclk_first = -1; fr_cs_rise = -1; fr_busy_fall = -1;
        fr_valid_cnt = 0; fr_err_cnt = 0; fr_both = 0; fr_valid_cyc = -1; fr_rises = 0;
        fr_value = 'x; fr_mosi = '0; fr_busy_at_start = 1'b0; fr_timeout = 1'b0;
        n = 0;
        while (spi.adc_cs_n !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (spi.adc_cs_n !== 1'b0) begin
            fr_timeout = 1'b1;
            return;
        end
        fr_start         = cyc;
        fr_busy_at_start = busy;
        mf               = {6'($urandom), nullb, data};
        miso_drv         = mf[16];
        prev_sclk        = spi.adc_sclk;
        prev_cs          = spi.adc_cs_n;
        n = 0;
        while (n < BUDGET) begin
            @(negedge clk);
            n++;
            if (n == drop_enable_at) enable = 1'b0;
            if (spi.adc_sclk && !prev_sclk) begin
                if (fr_rises == 0) fr_sclk_first = cyc;
                if (fr_rises < 17) fr_mosi = {fr_mosi[15:0], spi.adc_mosi};
                fr_rises++;
            end
            if (!spi.adc_sclk && prev_sclk) begin
                mf       = mf << 1;
                miso_drv = mf[16];
            end
            if (sample_valid) begin
                fr_valid_cnt++;
                fr_valid_cyc = cyc;
                fr_value     = sample_value;
            end
            if (frame_err) fr_err_cnt++;
            if (sample_valid && frame_err) fr_both++;
            if (spi.adc_cs_n && !prev_cs && fr_cs_rise < 0) fr_cs_rise = cyc;
            prev_sclk = spi.adc_sclk;
            prev_cs   = spi.adc_cs_n;
            if (!busy) begin
                fr_busy_fall = cyc;
                break;
            end
        end
        if (busy) fr_timeout = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi.adc_cs_n, spi.adc_sclk, spi.adc_mosi} !== 3'b100) begin
            errors++;
            $display("FAIL reset_spi: cs_n/sclk/mosi got %b expected 100",
                     {spi.adc_cs_n, spi.adc_sclk, spi.adc_mosi});
        end
        checks++;
        if ({sample_value, sample_valid, frame_err, busy, led} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: value=%h valid=%b err=%b busy=%b led=%b expected all 0",
                     sample_value, sample_valid, frame_err, busy, led);
        end
        reset    = 1'b0;
        rst_base = cyc;
        @(negedge clk);
        checks++;
        if (spi.adc_cs_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: cs_n=%b busy=%b expected 1/0", spi.adc_cs_n, busy);
        end
    endtask

    task automatic test_basic_frame();
        logic [16:0] exp_mosi;
        exp_mosi = {2'b11, CHANNEL, 12'd0};
        run_frame(10'h2A5, 1'b0, -1);
        model_sample(10'h2A5, 1'b0);
        checks++;
        if (fr_timeout) begin
            errors++;
            $display("FAIL basic_timeout: got timeout expected a complete frame");
        end
        checks++;
        if (fr_start - rst_base != SP) begin
            errors++;
            $display("FAIL basic_first_cs: got %0d cycles after reset expected %0d", fr_start - rst_base, SP);
        end
        checks++;
        if (fr_busy_at_start !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_rise: got %b expected 1", fr_busy_at_start);
        end
        checks++;
        if (fr_sclk_first - fr_start != CD) begin
            errors++;
            $display("FAIL basic_first_sclk: got %0d expected %0d", fr_sclk_first - fr_start, CD);
        end
        checks++;
        if (fr_rises != 17) begin
            errors++;
            $display("FAIL basic_sclk_count: got %0d expected 17", fr_rises);
        end
        checks++;
        if (fr_mosi !== exp_mosi) begin
            errors++;
            $display("FAIL basic_mosi: got %b expected %b", fr_mosi, exp_mosi);
        end
        checks++;
        if (fr_valid_cnt != 1 || fr_err_cnt != 0) begin
            errors++;
            $display("FAIL basic_strobes: got valid=%0d err=%0d expected 1/0", fr_valid_cnt, fr_err_cnt);
        end
        checks++;
        if (fr_valid_cyc - fr_start != 35 * CD) begin
            errors++;
            $display("FAIL basic_valid_time: got %0d expected %0d", fr_valid_cyc - fr_start, 35 * CD);
        end
        checks++;
        if (fr_cs_rise - fr_start != 35 * CD) begin
            errors++;
            $display("FAIL basic_cs_rise: got %0d expected %0d", fr_cs_rise - fr_start, 35 * CD);
        end
        checks++;
        if (fr_busy_fall - fr_start != 36 * CD) begin
            errors++;
            $display("FAIL basic_busy_fall: got %0d expected %0d", fr_busy_fall - fr_start, 36 * CD);
        end
        checks++;
        if (fr_value !== model_value || sample_value !== model_value) begin
            errors++;
            $display("FAIL basic_value: got %h/%h expected %h", fr_value, sample_value, model_value);
        end
        checks++;
        if (led !== model_led) begin
            errors++;
            $display("FAIL basic_led: got %b expected %b", led, model_led);
        end
    endtask

    task automatic test_hysteresis();
        logic [9:0] seq [7];
        seq = '{10'd400, 10'd240, 10'd260, 10'd250, 10'd300, 10'd301, 10'd249};
        for (int i = 0; i < 7; i++) begin
            run_frame(seq[i], 1'b0, -1);
            model_sample(seq[i], 1'b0);
            checks++;
            if (fr_timeout || fr_valid_cnt != 1 || fr_err_cnt != 0) begin
                errors++;
                $display("FAIL hyst_strobe[%0d]: timeout=%b valid=%0d err=%0d expected 0/1/0",
                         i, fr_timeout, fr_valid_cnt, fr_err_cnt);
            end
            checks++;
            if (fr_value !== model_value) begin
                errors++;
                $display("FAIL hyst_value[%0d]: got %0d expected %0d", i, fr_value, model_value);
            end
            checks++;
            if (led !== model_led) begin
                errors++;
                $display("FAIL hyst_led[%0d]: sample %0d got led=%b expected %b", i, seq[i], led, model_led);
            end
        end
    endtask

    task automatic test_frame_error();
        run_frame(10'h3FF, 1'b1, -1);
        model_sample(10'h3FF, 1'b1);
        checks++;
        if (fr_timeout || fr_err_cnt != 1 || fr_valid_cnt != 0 || fr_both != 0) begin
            errors++;
            $display("FAIL err_strobes: timeout=%b err=%0d valid=%0d both=%0d expected 0/1/0/0",
                     fr_timeout, fr_err_cnt, fr_valid_cnt, fr_both);
        end
        checks++;
        if (sample_value !== model_value || led !== model_led) begin
            errors++;
            $display("FAIL err_hold: got value=%h led=%b expected %h/%b", sample_value, led, model_value, model_led);
        end
        run_frame(10'h000, 1'b0, -1);
        model_sample(10'h000, 1'b0);
        checks++;
        if (fr_timeout || fr_valid_cnt != 1 || fr_value !== model_value || led !== model_led) begin
            errors++;
            $display("FAIL err_recover: valid=%0d value=%h led=%b expected 1/%h/%b",
                     fr_valid_cnt, fr_value, led, model_value, model_led);
        end
    endtask

    task automatic test_enable();
        int         bad;
        int         base;
        logic [9:0] v;
        enable = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (spi.adc_cs_n !== 1'b1 || sample_valid || frame_err || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL enable_off_quiet: got %0d active cycles expected 0", bad);
        end
        enable = 1'b1;
        base   = cyc;
        v      = 10'($urandom_range(0, 1023));
        run_frame(v, 1'b0, 20);
        model_sample(v, 1'b0);
        checks++;
        if (fr_start - base != SP) begin
            errors++;
            $display("FAIL enable_restart: got %0d cycles expected %0d", fr_start - base, SP);
        end
        checks++;
        if (fr_timeout || fr_valid_cnt != 1 || fr_value !== model_value || led !== model_led) begin
            errors++;
            $display("FAIL enable_drop_frame: valid=%0d value=%h led=%b expected 1/%h/%b",
                     fr_valid_cnt, fr_value, led, model_value, model_led);
        end
        bad = 0;
        repeat (2 * SP + 50) begin
            @(negedge clk);
            if (spi.adc_cs_n !== 1'b1 || sample_valid || frame_err) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL enable_drop_quiet: got %0d active cycles expected 0", bad);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int         n;
        int         rises;
        int         base;
        int         bad;
        logic       prev_sclk;
        logic [9:0] v;
        n = 0;
        while (spi.adc_cs_n !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        rises = 0;
        prev_sclk = spi.adc_sclk;
        while (rises < 10 && n < 2 * BUDGET) begin
            @(negedge clk);
            n++;
            if (spi.adc_sclk && !prev_sclk) rises++;
            prev_sclk = spi.adc_sclk;
        end
        checks++;
        if (rises != 10 || spi.adc_cs_n !== 1'b0 || spi.adc_sclk !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reach_idx9: rises=%0d cs_n=%b sclk=%b expected 10/0/1",
                     rises, spi.adc_cs_n, spi.adc_sclk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (spi.adc_cs_n !== 1'b1 || spi.adc_sclk !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: cs_n=%b sclk=%b expected 1/0", spi.adc_cs_n, spi.adc_sclk);
        end
        model_value = 10'd0;
        model_led   = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if ({spi.adc_cs_n, spi.adc_sclk, spi.adc_mosi} !== 3'b100 ||
                {sample_value, sample_valid, frame_err, busy, led} !== 14'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_outputs: got %0d cycles off reset values expected 0", bad);
        end
        reset = 1'b0;
        base  = cyc;
        v     = 10'($urandom_range(0, 1023));
        run_frame(v, 1'b0, -1);
        model_sample(v, 1'b0);
        checks++;
        if (fr_start - base != SP) begin
            errors++;
            $display("FAIL midrst_first_frame: got %0d cycles expected %0d", fr_start - base, SP);
        end
        checks++;
        if (fr_timeout || fr_valid_cnt != 1 || fr_value !== model_value || led !== model_led) begin
            errors++;
            $display("FAIL midrst_sample: valid=%0d value=%h led=%b expected 1/%h/%b",
                     fr_valid_cnt, fr_value, led, model_value, model_led);
        end
    endtask

    task automatic test_back_to_back();
        int         prev_start;
        int         prev_rise;
        logic [9:0] v;
        logic       nb;
        prev_start = -1;
        prev_rise  = -1;
        for (int k = 0; k < 6; k++) begin
            v  = (k == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
            nb = (k == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
            run_frame(v, nb, -1);
            model_sample(v, nb);
            if (prev_start >= 0) begin
                checks++;
                if (fr_start - prev_start != SP) begin
                    errors++;
                    $display("FAIL b2b_period[%0d]: got %0d expected %0d", k, fr_start - prev_start, SP);
                end
                checks++;
                if (fr_start - prev_rise < CD) begin
                    errors++;
                    $display("FAIL b2b_cs_gap[%0d]: got %0d expected >= %0d", k, fr_start - prev_rise, CD);
                end
            end
            checks++;
            if (fr_timeout || fr_valid_cnt != (nb ? 0 : 1) || fr_err_cnt != (nb ? 1 : 0) || fr_both != 0) begin
                errors++;
                $display("FAIL b2b_strobes[%0d]: valid=%0d err=%0d null=%b timeout=%b",
                         k, fr_valid_cnt, fr_err_cnt, nb, fr_timeout);
            end
            checks++;
            if (sample_value !== model_value || led !== model_led) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got value=%h led=%b expected %h/%b",
                         k, sample_value, led, model_value, model_led);
            end
            prev_start = fr_start;
            prev_rise  = fr_cs_rise;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        test_reset();
        test_basic_frame();
        test_hysteresis();
        test_frame_error();
        test_enable();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldr_adc_reader.md
Name: ldr_adc_reader

Overview:
- SPI master that periodically reads a 10-bit light-sensor value from an MCP3008-style ADC on a selectable single-ended channel.
- Publishes each sample with a one-cycle valid strobe.
- Drives a hysteresis-controlled "dark" LED.
- Sits between the FPGA board's ADC header and the sensor/LED application logic; it is the real-hardware acquisition path for the light sensor.

Parameters:
- CLK_DIV, 25: clk cycles per SCLK half-period (1 MHz SCLK at 50 MHz clk); must be >= 1.
- SAMPLE_PERIOD, 100000: clk cycles between sample triggers; must be >= 36*CLK_DIV+2.
- CHANNEL, 3'd0: ADC channel D2..D0.
- LED_ON_BELOW, 10'd250: LED turns on when a sample is < this value.
- LED_OFF_ABOVE, 10'd300: LED turns off when a sample is > this value; must be > LED_ON_BELOW.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = sample timer runs; 0 = timer held at 0
- adc_miso  in  1  ADC Dout
- adc_cs_n  out  1  ADC chip select, active low
- adc_sclk  out  1  SPI clock, mode 0 (idle low)
- adc_mosi  out  1  ADC Din
- sample_value  out  10  last good sample, B9 = MSB
- sample_valid  out  1  one-cycle strobe when sample_value updates
- frame_err  out  1  one-cycle strobe when the null bit was not 0
- busy  out  1  high from CS_SETUP through CS_HOLD
- led  out  1  dark indicator with hysteresis

Behaviour:
- Clock and reset: clk, asynchronous active-high reset. All outputs are registered.
- Reset values: adc_cs_n=1, adc_sclk=0, adc_mosi=0, sample_value=0, sample_valid=0, frame_err=0, busy=0, led=0. Timer=0, FSM=IDLE.
- Reset mid-frame: adc_cs_n returns to 1 immediately (asynchronously); no strobe is produced.
- Timer:
  - While enable=1, counts 0..SAMPLE_PERIOD-1 and wraps.
  - The wrap cycle produces tick.
  - While enable=0, the timer is held at 0 and no tick occurs; a frame already in progress completes normally.
  - A tick while busy=1 is dropped; it is not queued.
- FSM states: IDLE, CS_SETUP, SCLK_HIGH, SCLK_LOW, CS_HOLD.
  - IDLE: on tick -> CS_SETUP. adc_cs_n=0 and busy=1 from the next cycle; bit index=0; adc_mosi = bit 0.
  - CS_SETUP: lasts CLK_DIV cycles -> SCLK_HIGH.
  - SCLK_HIGH: adc_sclk=1 for CLK_DIV cycles. adc_miso is sampled in the first cycle of SCLK_HIGH (rising edge) -> SCLK_LOW.
  - SCLK_LOW: adc_sclk=0 for CLK_DIV cycles. adc_mosi is updated to the next bit on entry (falling edge). At the end, index<16 -> index+1, SCLK_HIGH; index==16 -> CS_HOLD with adc_cs_n=1.
  - CS_HOLD: adc_cs_n=1 for CLK_DIV cycles, busy stays 1 -> IDLE (busy=0).
- Frame: 17 SCLK cycles, index 0..16.
  - MOSI: idx0=1 (start), idx1=1 (SGL), idx2..4 = CHANNEL[2:0], idx>=5 = 0.
  - MISO: idx0..5 ignored; idx6 = null bit (expected 0); idx7..16 = B9..B0, shifted MSB first.
- Result, in the first cycle of CS_HOLD:
  - Null bit 0: sample_value <= shifted data and sample_valid=1 for exactly one cycle.
  - Null bit 1: frame_err=1 for one cycle; sample_value, sample_valid and led are unchanged.
  - sample_valid and frame_err are never high together.
- Latency (tick at cycle T): adc_cs_n falls at T+1; first SCLK rise at T+1+CLK_DIV; adc_cs_n rises and the strobe fires at T+1+35*CLK_DIV; busy falls at T+1+36*CLK_DIV.
- LED hysteresis: evaluated only on a good sample, using the new value, registered in the same cycle as sample_valid.
  - value < LED_ON_BELOW -> led=1.
  - value > LED_OFF_ABOVE -> led=0.
  - Otherwise led holds.
  - Comparisons are unsigned 10-bit.
  - Boundaries: exactly LED_ON_BELOW or exactly LED_OFF_ABOVE leaves led unchanged.
- Edge values: sample 10'h000 and 10'h3FF are handled without wrap; the shift register is exactly 10 bits.

Test Plan:
- Bench parameters: CLK_DIV=2, SAMPLE_PERIOD=200, CHANNEL=3'd5.
1. Reset, enable=1, ADC model returns 10'h2A5 with null=0 -> MOSI bits 1,1,1,0,1,0...; 17 SCLK rises; sample_valid one cycle at tick+71 with sample_value=10'h2A5; busy low at tick+73.
2. Hysteresis: sample sequence 400, 240, 260, 250, 300, 301, 249 -> led 0, 1, 1, 1, 1, 0, 1.
3. Null bit forced to 1 with data 10'h3FF -> frame_err pulse, no sample_valid, sample_value and led unchanged; the next good frame of 10'h000 gives sample_value=0 and led=1.
4. enable=0 for 1000 cycles -> adc_cs_n stays 1 and no strobes; enable dropped mid-frame -> that frame completes with one sample_valid, then nothing more.
5. Reset asserted at SCLK index 9 -> adc_cs_n=1 and adc_sclk=0 with no clk edge; all outputs at reset values; after release, the first frame starts at the first timer wrap (cycle 199).
6. Back-to-back operation: check adc_cs_n stays high >= CLK_DIV cycles between frames, and exactly one frame per SAMPLE_PERIOD over 5 periods.
